// File: rtl/issue_queue.sv
// Eight-entry collapsing issue queue: valid entries stay packed from slot 0, oldest first.
// Up to two pops by slot index and two appends per cycle; all outputs are registered.
`ifndef IQ_ENTRY_SIZE
`define IQ_ENTRY_SIZE 16
`endif

module issue_queue #(
   parameter int NUM_IQ_ENTRIES      = 8,
   parameter int NUM_IQ_ENTRIES_LOG2 = 3,
   parameter int IQ_ENTRY_SIZE       = `IQ_ENTRY_SIZE
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   output logic [NUM_IQ_ENTRIES_LOG2:0]   free,
   input  logic                           pop0,
   input  logic [NUM_IQ_ENTRIES_LOG2-1:0] pop_key0,
   input  logic                           pop1,
   input  logic [NUM_IQ_ENTRIES_LOG2-1:0] pop_key1,
   input  logic                           push0,
   input  logic [IQ_ENTRY_SIZE-1:0]       push_data0,
   input  logic                           push1,
   input  logic [IQ_ENTRY_SIZE-1:0]       push_data1,
   output logic [IQ_ENTRY_SIZE-1:0]       data0,
   output logic [IQ_ENTRY_SIZE-1:0]       data1,
   output logic [IQ_ENTRY_SIZE-1:0]       data2,
   output logic [IQ_ENTRY_SIZE-1:0]       data3,
   output logic [IQ_ENTRY_SIZE-1:0]       data4,
   output logic [IQ_ENTRY_SIZE-1:0]       data5,
   output logic [IQ_ENTRY_SIZE-1:0]       data6,
   output logic [IQ_ENTRY_SIZE-1:0]       data7
);

   localparam int CW = NUM_IQ_ENTRIES_LOG2 + 1;
   localparam logic [CW-1:0] FULL = CW'(NUM_IQ_ENTRIES);

   logic [NUM_IQ_ENTRIES-1:0] valid_q, valid_d, keep;
   logic [IQ_ENTRY_SIZE-1:0]  data_q [NUM_IQ_ENTRIES];
   logic [IQ_ENTRY_SIZE-1:0]  data_d [NUM_IQ_ENTRIES];
   logic [CW-1:0]             free_q, free_d;
   logic [CW-1:0]             cnt;

   // A slot survives if it is valid and neither pop port names it; a shared key removes it once.
   generate
      for (genvar gi = 0; gi < NUM_IQ_ENTRIES; gi++) begin : g_keep
         assign keep[gi] = valid_q[gi]
                         & ~(pop0 && (pop_key0 == NUM_IQ_ENTRIES_LOG2'(gi)))
                         & ~(pop1 && (pop_key1 == NUM_IQ_ENTRIES_LOG2'(gi)));
      end
   endgenerate

   // Survivors are packed in order, then push0 and push1 are appended while room remains.
   always_comb begin
      valid_d = '0;
      cnt     = '0;
      for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
         data_d[i] = '0;
      end
      for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
         if (keep[i]) begin
            data_d[cnt[NUM_IQ_ENTRIES_LOG2-1:0]]  = data_q[i];
            valid_d[cnt[NUM_IQ_ENTRIES_LOG2-1:0]] = 1'b1;
            cnt = cnt + 1'b1;
         end
      end
      if (push0 && (cnt < FULL)) begin
         data_d[cnt[NUM_IQ_ENTRIES_LOG2-1:0]]  = push_data0;
         valid_d[cnt[NUM_IQ_ENTRIES_LOG2-1:0]] = 1'b1;
         cnt = cnt + 1'b1;
      end
      if (push1 && (cnt < FULL)) begin
         data_d[cnt[NUM_IQ_ENTRIES_LOG2-1:0]]  = push_data1;
         valid_d[cnt[NUM_IQ_ENTRIES_LOG2-1:0]] = 1'b1;
         cnt = cnt + 1'b1;
      end
      free_d = FULL - cnt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         valid_q <= '0;
         free_q  <= FULL;
         for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         free_q  <= free_d;
         for (int i = 0; i < NUM_IQ_ENTRIES; i++) begin
            data_q[i] <= data_d[i];
         end
      end
   end

   assign free  = free_q;
   assign data0 = data_q[0];
   assign data1 = data_q[1];
   assign data2 = data_q[2];
   assign data3 = data_q[3];
   assign data4 = data_q[4];
   assign data5 = data_q[5];
   assign data6 = data_q[6];
   assign data7 = data_q[7];

endmodule

// File: tb/tb_issue_queue.sv
// Scoreboard bench for issue_queue: a queue-based reference model predicts each edge,
// predictions are pushed on drive and popped/compared one cycle later.
module tb_issue_queue;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n, flush;
   logic [3:0]   free;
   logic         pop0, pop1, push0, push1;
   logic [2:0]   pop_key0, pop_key1;
   logic [W-1:0] push_data0, push_data1;
   logic [W-1:0] data0, data1, data2, data3, data4, data5, data6, data7;

   always #5 clk = ~clk;

   issue_queue #(.NUM_IQ_ENTRIES(8), .NUM_IQ_ENTRIES_LOG2(3), .IQ_ENTRY_SIZE(W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .free(free),
      .pop0(pop0), .pop_key0(pop_key0), .pop1(pop1), .pop_key1(pop_key1),
      .push0(push0), .push_data0(push_data0), .push1(push1), .push_data1(push_data1),
      .data0(data0), .data1(data1), .data2(data2), .data3(data3),
      .data4(data4), .data5(data5), .data6(data6), .data7(data7)
   );

   typedef struct packed {
      logic [3:0]        free;
      logic [7:0][W-1:0] d;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] model[$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           n_steps  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] slot(input int i);
      case (i)
         0: return data0; 1: return data1; 2: return data2; 3: return data3;
         4: return data4; 5: return data5; 6: return data6; default: return data7;
      endcase
   endfunction

   // Reference model: drop popped positions from the list, then append while room remains.
   task automatic model_update();
      logic [W-1:0] nq[$];
      if (!rst_n || flush) begin
         model = {};
         return;
      end
      nq = {};
      for (int i = 0; i < model.size(); i++) begin
         if (!((pop0 && int'(pop_key0) == i) || (pop1 && int'(pop_key1) == i)))
            nq.push_back(model[i]);
      end
      if (push0 && nq.size() < 8) nq.push_back(push_data0);
      if (push1 && nq.size() < 8) nq.push_back(push_data1);
      model = nq;
   endtask

   task automatic step();
      exp_t e, got;
      model_update();
      e.free = 4'(8 - model.size());
      for (int i = 0; i < 8; i++) e.d[i] = (i < model.size()) ? model[i] : '0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      n_steps++;
      got = sb.pop_front();
      check("free", 32'(free), 32'(got.free));
      for (int i = 0; i < 8; i++) check($sformatf("data%0d", i), 32'(slot(i)), 32'(got.d[i]));
      $display("step %0d: free=%0d d=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d", n_steps, free,
               data0, data1, data2, data3, data4, data5, data6, data7);
   endtask

   task automatic idle();
      flush = 0; pop0 = 0; pop1 = 0; push0 = 0; push1 = 0;
      pop_key0 = 0; pop_key1 = 0; push_data0 = 0; push_data1 = 0;
   endtask

   initial begin
      int fill_free[4];
      int d_exp[8];
      fill_free = '{6, 4, 2, 0};
      rst_n = 0;
      idle();
      step();
      check("reset_free", 32'(free), 32'd8);
      check("reset_data0", 32'(data0), 32'd0);
      rst_n = 1;
      step();
      check("idle_free", 32'(free), 32'd8);

      // Fill from empty with pops aimed at invalid slots
      push0 = 1; push_data0 = 15; push1 = 1; push_data1 = 255;
      pop0 = 1; pop_key0 = 6; pop1 = 1; pop_key1 = 7;
      for (int k = 0; k < 4; k++) begin
         step();
         check($sformatf("fill_free%0d", k), 32'(free), 32'(fill_free[k]));
      end
      for (int i = 0; i < 8; i++)
         check($sformatf("fill_d%0d", i), 32'(slot(i)), (i % 2 == 0) ? 32'd15 : 32'd255);

      // Full queue: pop and push in the same cycle
      for (int k = 0; k < 4; k++) step();
      check("full_free", 32'(free), 32'd0);
      check("full_d7", 32'(data7), 32'd255);

      // Drain two slots, then repeat pops on now-invalid slots
      push0 = 0; push1 = 0;
      step();
      check("drain_free", 32'(free), 32'd2);
      check("drain_d6", 32'(data6), 32'd0);
      step(); step();
      check("drain_hold", 32'(free), 32'd2);

      // Compaction: load A..H (1..8), pop slots 2 and 5, push X=100 Y=200
      idle(); flush = 1; step(); flush = 0;
      for (int k = 0; k < 4; k++) begin
         push0 = 1; push_data0 = W'(2 * k + 1); push1 = 1; push_data1 = W'(2 * k + 2);
         step();
      end
      pop0 = 1; pop_key0 = 2; pop1 = 1; pop_key1 = 5;
      push_data0 = 100; push_data1 = 200;
      step();
      d_exp = '{1, 2, 4, 5, 7, 8, 100, 200};
      for (int i = 0; i < 8; i++) check($sformatf("cmp_d%0d", i), 32'(slot(i)), 32'(d_exp[i]));

      // Same key on both pop ports removes one entry
      idle(); pop0 = 1; pop1 = 1;
      step();
      check("samekey_free", 32'(free), 32'd1);
      check("samekey_d0", 32'(data0), 32'd2);

      // Overflow: one slot left, both pushes -> only push0 lands
      idle(); push0 = 1; push_data0 = 77; push1 = 1; push_data1 = 88;
      step();
      check("ovf_free", 32'(free), 32'd0);
      check("ovf_d7", 32'(data7), 32'd77);

      // Flush with pushes active
      flush = 1;
      step();
      check("flush_free", 32'(free), 32'd8);
      check("flush_d0", 32'(data0), 32'd0);
      flush = 0; idle();

      // Random traffic including occasional flush and reset
      for (int k = 0; k < 150; k++) begin
         rst_n      = ($urandom_range(0, 39) != 0);
         flush      = ($urandom_range(0, 29) == 0);
         pop0       = $urandom_range(0, 1);
         pop1       = $urandom_range(0, 1);
         pop_key0   = 3'($urandom_range(0, 7));
         pop_key1   = 3'($urandom_range(0, 7));
         push0      = $urandom_range(0, 1);
         push1      = $urandom_range(0, 1);
         push_data0 = W'($urandom);
         push_data1 = W'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
